instruction_fetch: RTL and testbench

- Fetch stage of the 5-stage RISC-V pipeline: owns the program counter and drives the instruction ROM address.
- Consumes the ROM's asynchronous 32-bit read data and registers it into the IF/ID pipeline register with its PC and a valid bit.
- Accepts stall from hazard detection and redirect (taken branch / jump) from EX.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/instruction_fetch_if_id_reg.sv | 47 ++++
 rtl/instruction_fetch.sv | 97 +++++++++
 tb/tb_instruction_fetch.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: the IF/ID pipeline record and the canonical NOP.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } if_id_t;

    // Instruction addresses are word-aligned; the low two bits are always dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold on stall, or insert a bubble.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_instr,
    output if_id_t      if_id
);

    if_id_t if_id_d;
    if_id_t if_id_q;

    // Next IF/ID contents; a bubble keeps the PC fields and only kills valid/instr.
    always_comb begin
        if_id_d = if_id_q;
        if (bubble) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end else if (load) begin
            if_id_d.valid    = 1'b1;
            if_id_d.pc       = fetch_pc;
            if_id_d.pc_plus4 = fetch_pc + 32'd4;
            if_id_d.instr    = fetch_instr;
        end else begin
            if_id_d = if_id_q;
        end
    end

    // IF/ID state register with synchronous reset to a NOP bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q.valid    <= 1'b0;
            if_id_q.pc       <= 32'h0000_0000;
            if_id_q.pc_plus4 <= 32'h0000_0004;
            if_id_q.instr    <= NOP_INSTR;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_id = if_id_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the instruction ROM and fills IF/ID.
// Optional FETCH_MISALIGN_CHK_EN adds a sticky fetch_misaligned flag for unaligned redirects.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    output logic                  if_id_valid,
    output logic [31:0]           if_id_pc,
    output logic [31:0]           if_id_pc_plus4,
    output logic [31:0]           if_id_instr
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic                  fetch_misaligned
`endif
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;
    logic        load_s;
    if_id_t      if_id_s;

    // Next PC: redirect beats stall, otherwise step one word (wraps modulo 2^32).
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= align_pc(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    // The ROM address depends on the PC register only, never on this cycle's controls.
    assign imem_addr = pc_q[ADDR_WIDTH-1:0];
    assign load_s    = ~stall & ~redirect_valid;

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (load_s),
        .bubble      (redirect_valid),
        .fetch_pc    (pc_q),
        .fetch_instr (imem_rdata),
        .if_id       (if_id_s)
    );

    assign if_id_valid    = if_id_s.valid;
    assign if_id_pc       = if_id_s.pc;
    assign if_id_pc_plus4 = if_id_s.pc_plus4;
    assign if_id_instr    = if_id_s.instr;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misaligned_d;
    logic misaligned_q;

    // Sticky flag: any redirect with nonzero low target bits latches it until reset.
    always_comb begin
        misaligned_d = misaligned_q;
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misaligned_d = 1'b1;
        end else begin
            misaligned_d = misaligned_q;
        end
    end

    // Misalignment flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign fetch_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes the expected post-edge state,
// a monitor on the falling edge pops and compares it against the DUT outputs.
module tb_instruction_fetch;

    localparam int          AW    = 12;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    typedef struct {
        logic           valid;
        logic [31:0]    pc;
        logic [31:0]    pc_plus4;
        logic [31:0]    instr;
        logic [AW-1:0]  addr;
        logic           mis;
        string          tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          if_id_valid;
    logic [31:0]   if_id_pc;
    logic [31:0]   if_id_pc_plus4;
    logic [31:0]   if_id_instr;
`ifdef FETCH_MISALIGN_CHK_EN
    logic          fetch_misaligned;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    // Reference model state
    logic [31:0] m_pc;
    exp_t        m_st;

    instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    // ROM contents: the test program in words 0..3, an address tag elsewhere.
    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        case (a[AW-1:2])
            10'd0:   return 32'h0050_0093;
            10'd1:   return 32'h0010_0113;
            10'd2:   return 32'h0020_81B3;
            10'd3:   return 32'h0000_0013;
            default: return {20'hA0000, a};
        endcase
    endfunction

    assign imem_rdata = rom_word(imem_addr);

    // Apply one cycle of controls, advance the model, push the expected post-edge state.
    task automatic step(input logic r, input logic s, input logic rv,
                        input logic [31:0] rp, input string tag);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        if (r) begin
            m_pc = RPC;
            m_st.valid = 1'b0; m_st.pc = 32'h0; m_st.pc_plus4 = 32'h4;
            m_st.instr = NOP_W; m_st.mis = 1'b0;
        end else if (rv) begin
            m_st.valid = 1'b0; m_st.instr = NOP_W;
            if (rp[1:0] != 2'b00) m_st.mis = 1'b1;
            m_pc = {rp[31:2], 2'b00};
        end else if (!s) begin
            m_st.valid = 1'b1; m_st.pc = m_pc; m_st.pc_plus4 = m_pc + 32'd4;
            m_st.instr = rom_word(m_pc[AW-1:0]);
            m_pc = m_pc + 32'd4;
        end
        m_st.addr = m_pc[AW-1:0];
        m_st.tag  = tag;
        @(posedge clk);
        sb_q.push_back(m_st);
        #1;
    endtask

    // Monitor: one expected record per edge, compared on the following falling edge.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e  = sb_q.pop_front();
                ok = (if_id_valid === e.valid) && (if_id_instr === e.instr) &&
                     (if_id_pc === e.pc) && (if_id_pc_plus4 === e.pc_plus4) &&
                     (imem_addr === e.addr);
`ifdef FETCH_MISALIGN_CHK_EN
                ok = ok && (fetch_misaligned === e.mis);
`endif
                n_cmp++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL %s: got v=%b pc=%h p4=%h ins=%h addr=%h, need v=%b pc=%h p4=%h ins=%h addr=%h mis=%b",
                             e.tag, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, imem_addr,
                             e.valid, e.pc, e.pc_plus4, e.instr, e.addr, e.mis);
                end
            end
        end
    end

    initial begin
        m_pc = RPC;
        m_st.valid = 1'b0; m_st.pc = 32'h0; m_st.pc_plus4 = 32'h4;
        m_st.instr = NOP_W; m_st.mis = 1'b0; m_st.addr = '0; m_st.tag = "init";
        #2;
        step(1'b1, 1'b1, 1'b1, 32'h0000_0044, "reset_a");
        step(1'b1, 1'b0, 1'b0, 32'h0, "reset_b");
        // Free run from RESET_PC, then stall three cycles with pc=8
        step(1'b0, 1'b0, 1'b0, 32'h0, "run_pc0");
        step(1'b0, 1'b0, 1'b0, 32'h0, "run_pc4");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, "stall_pc8");
        step(1'b0, 1'b0, 1'b0, 32'h0, "release_pc8");
        step(1'b0, 1'b0, 1'b0, 32'h0, "run_pc12");
        // Redirect while pc=0x10
        step(1'b0, 1'b0, 1'b1, 32'h0000_0040, "redir_40");
        step(1'b0, 1'b0, 1'b0, 32'h0, "after_redir_40");
        step(1'b0, 1'b1, 1'b1, 32'h0000_0020, "stall_and_redir_20");
        step(1'b0, 1'b0, 1'b0, 32'h0, "after_redir_20");
        // ROM address wrap at 2^AW
        step(1'b0, 1'b0, 1'b1, 32'h0000_0FFC, "redir_ffc");
        step(1'b0, 1'b0, 1'b0, 32'h0, "fetch_ffc");
        step(1'b0, 1'b0, 1'b0, 32'h0, "fetch_1000");
        // Full 32-bit PC wrap
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, "redir_top");
        step(1'b0, 1'b0, 1'b0, 32'h0, "fetch_top");
        step(1'b0, 1'b0, 1'b0, 32'h0, "fetch_wrap0");
        // Unaligned target is masked; sticky flag when the check is built in
        step(1'b0, 1'b0, 1'b1, 32'h0000_0042, "redir_42");
        step(1'b0, 1'b0, 1'b0, 32'h0, "fetch_40");
        step(1'b0, 1'b0, 1'b1, 32'h0000_0080, "redir_80");
        step(1'b0, 1'b0, 1'b0, 32'h0, "fetch_80");
        // Mid-run reset with pending stall/redirect
        step(1'b1, 1'b1, 1'b1, 32'h0000_0123, "reset_mid");
        step(1'b0, 1'b0, 1'b0, 32'h0, "post_reset_pc0");
        step(1'b0, 1'b0, 1'b0, 32'h0, "post_reset_pc4");
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d records left, need 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
